// File: rtl/gsim_pkg.sv
// Shared parameters, FSM state type and band coefficients for the GSIM forward model (b = M*x).
package gsim_pkg;

    localparam int N    = 16;
    localparam int KW   = 4;
    localparam int XW   = 32;
    localparam int FRAC = 16;
    localparam int BW   = 16;
    localparam int ACCW = XW + 6;

    localparam int C0 = 20;
    localparam int C1 = -13;
    localparam int C2 = 6;
    localparam int C3 = -1;

    typedef enum logic {
        LOAD = 1'b0,
        CALC = 1'b1
    } state_t;

    // Band coefficient for offset d = j - k; the matrix is symmetric so only |d| matters.
    function automatic logic signed [ACCW-1:0] coef(input int d);
        logic signed [ACCW-1:0] c;
        c = '0;
        case (d)
            0:       c = ACCW'(C0);
            1, -1:   c = ACCW'(C1);
            2, -2:   c = ACCW'(C2);
            3, -3:   c = ACCW'(C3);
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gsim_mb_round.sv
// Combinational round-half-up of a Q16.16 accumulator to a BW-bit integer.
// With GSIM_MB_SAT_EN defined the result saturates and reports clipping; otherwise it wraps.
import gsim_pkg::*;

module gsim_mb_round (
    input  logic signed [ACCW-1:0] acc,
`ifdef GSIM_MB_SAT_EN
    output logic                   sat,
`endif
    output logic        [BW-1:0]   b
);

    logic signed [ACCW-1:0] biased;
    logic signed [ACCW-1:0] rounded;

    // Adding half an LSB then flooring makes exact ties round toward +infinity.
    assign biased  = acc + ACCW'(1 << (FRAC - 1));
    assign rounded = biased >>> FRAC;

`ifdef GSIM_MB_SAT_EN
    localparam logic signed [ACCW-1:0] B_MAX = ACCW'((1 << (BW - 1)) - 1);
    localparam logic signed [ACCW-1:0] B_MIN = ~B_MAX;

    always_comb begin
        sat = 1'b0;
        b   = rounded[BW-1:0];
        if (rounded > B_MAX) begin
            sat = 1'b1;
            b   = B_MAX[BW-1:0];
        end else if (rounded < B_MIN) begin
            sat = 1'b1;
            b   = B_MIN[BW-1:0];
        end
    end
`else
    assign b = rounded[BW-1:0];
`endif

endmodule

// File: rtl/gsim_mb.sv
// GSIM forward model: loads x[0..N-1], then streams b = M*x through a two-stage pipeline.
// Optional saturation with sat_flag output is enabled by defining GSIM_MB_SAT_EN.
import gsim_pkg::*;

module gsim_mb (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [XW-1:0] x_in,
    output logic          busy,
    output logic          out_valid,
    output logic [BW-1:0] b_out,
`ifdef GSIM_MB_SAT_EN
    output logic          sat_flag,
`endif
    output logic          done
);

    state_t                 state, state_nx;
    logic [KW-1:0]          count, count_nx;
    logic [KW-1:0]          k, k_nx;
    logic                   load_we;
    logic                   issue;

    logic signed [XW-1:0]   xr [N];
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] s1_sum;
    logic                   s1_valid;
    logic                   s1_last;
    logic                   out_last;
    logic [BW-1:0]          rnd_b;
`ifdef GSIM_MB_SAT_EN
    logic                   rnd_sat;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            count <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            k     <= k_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        k_nx     = k;
        load_we  = 1'b0;
        issue    = 1'b0;
        case (state)
            LOAD: begin
                if (in_en) begin
                    load_we  = 1'b1;
                    count_nx = count + 1'b1;
                    if (count == KW'(N - 1)) begin
                        state_nx = CALC;
                        count_nx = '0;
                        k_nx     = '0;
                    end
                end
            end
            CALC: begin
                issue = 1'b1;
                k_nx  = k + 1'b1;
                if (k == KW'(N - 1)) begin
                    state_nx = LOAD;
                    count_nx = '0;
                    k_nx     = '0;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) xr[i] <= '0;
        end else if (load_we) begin
            xr[count] <= x_in;
        end
    end

    // Row k of the band: taps k-3..k+3; an index below zero wraps past N and is skipped.
    always_comb begin
        logic [5:0] idx;
        sum = '0;
        idx = '0;
        for (int i = 0; i < 7; i++) begin
            idx = {2'b00, k} + 6'(i) - 6'd3;
            if (idx < 6'(N))
                sum = sum + coef(i - 3) * $signed({{(ACCW-XW){xr[idx[KW-1:0]][XW-1]}}, xr[idx[KW-1:0]]});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue && (k == KW'(N - 1));
            if (issue) s1_sum <= sum;
        end
    end

    gsim_mb_round u_round (
        .acc (s1_sum),
`ifdef GSIM_MB_SAT_EN
        .sat (rnd_sat),
`endif
        .b   (rnd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            b_out     <= '0;
            done      <= 1'b0;
`ifdef GSIM_MB_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            b_out     <= s1_valid ? rnd_b : '0;
            done      <= out_valid && out_last;
`ifdef GSIM_MB_SAT_EN
            sat_flag  <= s1_valid && rnd_sat;
`endif
        end
    end

endmodule

// File: tb/tb_gsim_mb.sv
// Scoreboard bench for gsim_mb: a row-by-row reference of b = M*x feeds an expected queue
// that a negedge monitor drains whenever out_valid is high.
import gsim_pkg::*;

module tb_gsim_mb;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_en;
    logic [XW-1:0] x_in;
    logic          busy;
    logic          out_valid;
    logic [BW-1:0] b_out;
    logic          done;
`ifdef GSIM_MB_SAT_EN
    logic          sat_flag;
`endif

    gsim_mb dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .x_in      (x_in),
        .busy      (busy),
        .out_valid (out_valid),
        .b_out     (b_out),
`ifdef GSIM_MB_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [BW-1:0] exp_q[$];
    logic          exp_sat_q[$];
    int          burst_cnt = 0;
    int          t_last = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint coef_m(input int d);
        int a;
        a = (d < 0) ? -d : d;
        case (a)
            0: return 20;
            1: return -13;
            2: return 6;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    // Reference: b[k] = floor((sum_j c(j-k)*x[j] + 2^15) / 2^16), then wrap or clamp to 16 bits.
    task automatic push_model(input logic [XW-1:0] v[N]);
        longint s, r;
        logic [63:0] rbits;
        for (int k = 0; k < N; k++) begin
            s = 0;
            for (int j = 0; j < N; j++)
                if (j >= k - 3 && j <= k + 3)
                    s += coef_m(j - k) * longint'($signed(v[j]));
            r = (s + 32768) >>> 16;
            rbits = r;
`ifdef GSIM_MB_SAT_EN
            if (r > 32767)       begin exp_q.push_back(16'h7fff); exp_sat_q.push_back(1'b1); end
            else if (r < -32768) begin exp_q.push_back(16'h8000); exp_sat_q.push_back(1'b1); end
            else                 begin exp_q.push_back(rbits[15:0]); exp_sat_q.push_back(1'b0); end
`else
            exp_q.push_back(rbits[15:0]);
            exp_sat_q.push_back(1'b0);
`endif
        end
    endtask

    task automatic push_list(input int vals[N], input logic [N-1:0] sat_mask);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(16'(vals[i]));
            exp_sat_q.push_back(sat_mask[i]);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [BW-1:0] e;
        logic          es;
        if (!reset) begin
            burst_cnt = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    es = exp_sat_q.pop_front();
                    check($sformatf("b_out[%0d]", burst_cnt), longint'($signed(b_out)), longint'($signed(e)));
`ifdef GSIM_MB_SAT_EN
                    check($sformatf("sat_flag[%0d]", burst_cnt), longint'(sat_flag), longint'(es));
`endif
                end
                burst_cnt++;
            end
            if (done) begin
                check("burst_len", burst_cnt, N);
                burst_cnt = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic load(input logic [XW-1:0] v[N], input bit gaps, input bit poke_busy);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_en = 1'b0;
                    x_in  = $urandom;
                    @(posedge clk); #1;
                end
            end
            in_en = 1'b1;
            x_in  = v[i];
            @(posedge clk); #1;
        end
        in_en  = 1'b0;
        t_last = cyc;
        @(posedge clk); #1;
        check("busy_in_calc", busy, 1);
        if (poke_busy) begin
            repeat (12) begin
                in_en = 1'($urandom_range(0, 1));
                x_in  = $urandom;
                @(posedge clk); #1;
            end
            in_en = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        if (seen) begin
            check({name, "_done_latency"}, cyc - t_last, N + 2);
            check({name, "_busy_low_at_done"}, busy, 0);
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
        exp_sat_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic run_model(input string name, input logic [XW-1:0] v[N], input bit gaps, input bit poke);
        push_model(v);
        load(v, gaps, poke);
        wait_done(name);
    endtask

    task automatic rand_vec(output logic [XW-1:0] v[N], input bit full_range);
        for (int i = 0; i < N; i++)
            v[i] = full_range ? XW'($urandom) : XW'(int'($urandom_range(0, 32'h0080_0000)) - 32'sh0040_0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [XW-1:0] v[N];
        logic [XW-1:0] vr[N];
        int            vals[N];
        int            n;

        reset = 1'b0;
        in_en = 1'b0;
        x_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_b_out", b_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // all zero
        for (int i = 0; i < N; i++) v[i] = '0;
        run_model("zeros", v, 0, 0);

        // impulse at x[0]
        v[0] = 32'h0001_0000;
        vals = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list(vals, '0);
        load(v, 0, 0);
        wait_done("impulse0");

        // impulse at x[7]
        v[0] = '0;
        v[7] = 32'h0001_0000;
        vals = '{0, 0, 0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0};
        push_list(vals, '0);
        load(v, 1, 0);
        wait_done("impulse7");

        // rounding of 0.5
        v[7] = '0;
        v[0] = 32'h0000_8000;
        vals = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list(vals, '0);
        load(v, 0, 0);
        wait_done("round_half");

        // overflow on element 0
        v[0] = 32'h0800_0000;
`ifdef GSIM_MB_SAT_EN
        vals = '{32767, -26624, 12288, -2048, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list(vals, 16'h0001);
`else
        vals = '{-24576, -26624, 12288, -2048, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_list(vals, '0);
`endif
        load(v, 0, 0);
        wait_done("overflow");

        // same random vector with and without gaps, then with in_en pokes during busy
        rand_vec(vr, 0);
        run_model("rand_nogap", vr, 0, 0);
        run_model("rand_gap", vr, 1, 0);
        run_model("rand_poke", vr, 0, 1);

        // reset at the 5th out_valid aborts the burst
        rand_vec(v, 0);
        push_model(v);
        load(v, 0, 0);
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("abort_reached_5th", n, 5);
        reset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_b_out", b_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        exp_sat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rand_vec(v, 0);
        run_model("after_abort", v, 1, 0);

        // full-range random vectors exercise wrap/saturation broadly
        for (int t = 0; t < 4; t++) begin
            rand_vec(v, 1);
            run_model($sformatf("rand_full%0d", t), v, 1, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
